// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM arbiter slice.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned RAM_BYTES  = 256;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        DONE
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the port not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       valid_c,
    output logic       winner_c
);

    logic [1:0] elig;

    always_comb begin
        elig     = req & ~mask;
        valid_c  = |elig;
        winner_c = 1'b0;
        if (elig == 2'b11) begin
            winner_c = ~last;
        end else if (elig[1]) begin
            winner_c = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the word-write RAM.
// Byte writes are turned into a read-modify-write of the containing word.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              byte0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic              byte1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out
);

    arb_state_e        state_q, state_d;
    logic              last_q;
    logic              port_q;
    logic              we_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack0_q;
    logic              ack1_q;

    logic              grant_valid_c;
    logic              winner_c;
    logic              arbitrate_c;
    logic              sel_we_c;
    logic              sel_byte_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [DATA_W-1:0] read_val_c;

    // A port whose ack is high is dropping its request next edge, so mask it.
    rr_pick2 u_pick (
        .req      ({req1, req0}),
        .mask     ({ack1_q, ack0_q}),
        .last     (last_q),
        .valid_c  (grant_valid_c),
        .winner_c (winner_c)
    );

    always_comb begin
        sel_we_c    = winner_c ? we1    : we0;
        sel_byte_c  = winner_c ? byte1  : byte0;
        sel_addr_c  = winner_c ? addr1  : addr0;
        sel_wdata_c = winner_c ? wdata1 : wdata0;
        arbitrate_c = ((state_q == IDLE) || (state_q == DONE)) && grant_valid_c;
        read_val_c  = (byte_q && !we_q) ? DATA_W'(mem_data_out[DATA_W-1 -: BYTE_W])
                                        : mem_data_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and RAM port drive; DONE arbitrates exactly like IDLE.
    always_comb begin
        state_d     = state_q;
        mem_we      = 1'b0;
        mem_data_in = wdata_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (grant_valid_c) begin
                    state_d = (sel_we_c && sel_byte_c) ? RMW_RD : ACCESS;
                end
            end
            ACCESS: begin
                mem_we  = we_q;
                state_d = DONE;
            end
            RMW_RD: begin
                state_d = RMW_WR;
            end
            RMW_WR: begin
                mem_we      = 1'b1;
                mem_data_in = merge_q;
                state_d     = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            if (arbitrate_c) begin
                last_q  <= winner_c;
                port_q  <= winner_c;
                we_q    <= sel_we_c;
                byte_q  <= sel_byte_c;
                addr_q  <= sel_addr_c;
                wdata_q <= sel_wdata_c;
            end
            if (state_q == ACCESS) begin
                rdata_q <= read_val_c;
            end
            if (state_q == RMW_RD) begin
                merge_q <= {wdata_q[BYTE_W-1:0], mem_data_out[DATA_W-BYTE_W-1:0]};
            end
            if ((state_q == ACCESS) || (state_q == RMW_WR)) begin
                ack0_q <= ~port_q;
                ack1_q <= port_q;
            end
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata       = rdata_q;
    assign mem_address = addr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256-byte big-endian RAM.
module tb_ram_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, byte0, req1, we1, byte1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, mem_we;
    logic [15:0] rdata, mem_address, mem_data_in, mem_data_out;

    logic [7:0]  ram [256];
    logic [7:0]  ra0, ra1;
    int          total = 0;
    int          bad = 0;
    int          we_viol = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .we0          (we0),
        .byte0        (byte0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .ack0         (ack0),
        .req1         (req1),
        .we1          (we1),
        .byte1        (byte1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .ack1         (ack1),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out)
    );

    // RAM model: combinational read, whole-word write on the falling edge.
    assign ra0          = mem_address[7:0];
    assign ra1          = ra0 + 8'd1;
    assign mem_data_out = {ram[ra0], ram[ra1]};

    always @(negedge clk) begin
        if (mem_we) begin
            ram[ra0] <= mem_data_in[15:8];
            ram[ra1] <= mem_data_in[7:0];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(mem_we && (dut.state_q == IDLE || dut.state_q == DONE)))
            else begin
                we_viol++;
                $display("FAIL we_idle_done mem_we=%0b state=%0d", mem_we, dut.state_q);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction on one port; returns posedges from request to ack.
    task automatic xfer(input int p, input logic w, input logic b, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd);
        bit got;
        @(negedge clk);
        if (p == 0) begin
            req0 = 1'b1; we0 = w; byte0 = b; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; byte1 = b; addr1 = a; wdata1 = d;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = (p == 0) ? ack0 : ack1;
        end
        rd = rdata;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int          lat;
        int          n;
        int          cyc;
        logic [15:0] rd;
        logic [15:0] exp_rd;
        bit          seen;
        int          exp_port [5];

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; byte0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; byte1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_address, 0);
        reset = 1'b0;

        // word write then read on port 0
        xfer(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, lat, rd);
        chk("wr_lat", lat, 2);
        chk("wr_mem10", ram[8'h10], 8'hBE);
        chk("wr_mem11", ram[8'h11], 8'hEF);
        xfer(0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd);
        chk("rd_lat", lat, 2);
        chk("rd_data", rd, 16'hBEEF);

        // byte write merges into the existing word
        xfer(1, 1'b1, 1'b0, 16'h0020, 16'h1234, lat, rd);
        chk("wr20_lat", lat, 2);
        xfer(0, 1'b1, 1'b1, 16'h0020, 16'hFFAB, lat, rd);
        chk("bw_lat", lat, 3);
        xfer(0, 1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd);
        chk("bw_word", rd, 16'hAB34);
        xfer(1, 1'b0, 1'b1, 16'h0021, 16'h0000, lat, rd);
        chk("br21_lat", lat, 2);
        chk("br21", rd, 16'h0034);
        xfer(1, 1'b0, 1'b1, 16'h0020, 16'h0000, lat, rd);
        chk("br20", rd, 16'h00AB);

        // both ports held: strict alternation, back-to-back every 2 cycles
        ram[8'h40] = 8'h11; ram[8'h41] = 8'h22;
        ram[8'h50] = 8'h33; ram[8'h51] = 8'h44;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; byte0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; byte1 = 1'b0; addr1 = 16'h0050;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ack0 || ack1) begin
                exp_rd = (n % 2 == 0) ? 16'h1122 : 16'h3344;
                chk("b2b_ack", {ack1, ack0}, (n % 2 == 0) ? 2'b01 : 2'b10);
                chk("b2b_cyc", cyc, 2 + 2 * n);
                chk("b2b_rdata", rdata, exp_rd);
                n++;
            end
        end
        chk("b2b_count", n, 6);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        // port 1 alone, then port 0 joins while port 1 keeps requesting
        ram[8'h60] = 8'h77; ram[8'h61] = 8'h88;
        exp_port = '{1, 1, 0, 1, 0};
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; byte1 = 1'b0; addr1 = 16'h0060;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ack0 || ack1) begin
                chk("rr_port", ack1 ? 1 : 0, exp_port[n]);
                n++;
                if (n == 2) begin
                    req0 = 1'b1; we0 = 1'b0; byte0 = 1'b0; addr0 = 16'h0040;
                end
            end
        end
        chk("rr_count", n, 5);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        // reset during RMW_RD drops the byte write and leaves memory alone
        xfer(1, 1'b1, 1'b0, 16'h0030, 16'h5566, lat, rd);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; byte0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h00CD;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_addr", mem_address, 0);
        req0 = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) seen = 1'b1;
        end
        chk("rst_mid_noack", seen, 0);
        reset = 1'b0;
        chk("rst_mid_m30", ram[8'h30], 8'h55);
        chk("rst_mid_m31", ram[8'h31], 8'h66);
        xfer(0, 1'b0, 1'b0, 16'h0030, 16'h0000, lat, rd);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_rd", rd, 16'h5566);

        // address change after latching is ignored
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; byte0 = 1'b0; addr0 = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        addr0 = 16'h0020;
        chk("latch_addr", mem_address, 16'h0010);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            seen = ack0;
        end
        chk("latch_ack", seen, 1);
        chk("latch_rd", rdata, 16'hBEEF);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        chk("we_idle_done", we_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer in front of the 256-byte, byte-addressed, big-endian `ram` block. It shares the RAM's single address/data/we port between two requesters: port 0 (CPU data) and port 1 (instruction fetch / loader). It grants requests round-robin and runs each transaction as a short fixed sequence. Byte writes become a read-modify-write, because the RAM only writes whole 16-bit words (`mem[a] <= d[15:8]`, `mem[a+1] <= d[7:0]`).

## Interface
- `ADDR_W`, default 16: width of all address buses.
- `DATA_W`, default 16: word width; byte lane is 8.

Ports (the `N` suffix applies to both port 0 and port 1):
- `clk`  in  1  system clock; the RAM writes on its negedge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqN`  in  1  request; held stable with its qualifiers until `ackN`.
- `weN`  in  1  1 = write, 0 = read.
- `byteN`  in  1  1 = byte access to `addrN`, 0 = word access at `addrN`/`addrN+1`.
- `addrN`  in  ADDR_W  byte address.
- `wdataN`  in  DATA_W  write data; for a byte write only `[7:0]` is used.
- `ackN`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  shared read data, valid while either ack is high; for a byte read it is `{8'h00, mem[addr]}`.
- `mem_address`  out  ADDR_W  to RAM `address`.
- `mem_data_in`  out  DATA_W  to RAM `data_in`.
- `mem_we`  out  1  to RAM `we`.
- `mem_data_out`  in  DATA_W  from RAM `data_out` (combinational read).

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
- **IDLE:** sample requests; a port whose ack is high this cycle is masked. If no request is eligible, stay in IDLE. Otherwise:
  - Pick the winner: if both ports request, the port not served last wins; the `last` pointer resets to 1, so port 0 wins the first tie.
  - Latch the winner's port, we, byte, addr and wdata.
  - Go to RMW_RD if this is a byte write, else to ACCESS.
- **ACCESS:**
  - `mem_we` = latched we.
  - On the posedge, capture `mem_data_out` into `rdata` (or `{8'h00, mem_data_out[15:8]}` for a byte read). Then go to DONE.
- **RMW_RD:** `mem_we` = 0. Capture merge = `{wdata[7:0], mem_data_out[7:0]}`, then go to RMW_WR.
- **RMW_WR:** `mem_we` = 1, `mem_data_in` = merge, then go to DONE.
- **DONE:**
  - Assert the winner's `ackN` for this cycle only.
  - `rdata` holds its value until the next capture.
  - Behaves as IDLE for the non-masked port: a pending request from the other port is latched on this edge, giving back-to-back service.
- Drive rules:
  - `mem_address` always equals the latched address.
  - `mem_data_in` is the latched wdata, or the merge value in RMW_WR.
  - `mem_we` is combinational from state, so it is never high in IDLE or DONE.
- No range checking. Word access at 0x00FF and addresses ≥ 0x0100 are requester errors and pass through unchanged.

## Timing
- Reset (async): state IDLE, `last` = 1, `ack0` = `ack1` = 0, `rdata` = 0, latched regs = 0, so `mem_we` = 0 and `mem_address` = 0 immediately.
- Word read/write: request sampled at edge E, ACCESS in cycle E+1, ack high in cycle E+2. Issue rate is one transaction per 2 cycles.
- Byte write: ack high in cycle E+3.
- Writes take effect at the negedge inside ACCESS or RMW_WR.
- Reset asserted mid-transaction:
  - The transaction is dropped and no ack is issued.
  - A write whose negedge has already occurred stays in memory.
  - An RMW reset in RMW_RD leaves memory unchanged.
- A requester changing `addrN`/`wdataN` while waiting has no effect once latched. Before latching, the new values are used.

## Structure
- Shared package `mem_pkg`: state enum (IDLE, ACCESS, RMW_RD, RMW_WR, DONE), `ADDR_W`/`DATA_W` defaults, RAM size constant 256.
- One sub-module, `rr_pick2`: 2-way round-robin selector. Inputs: req[1:0], mask[1:0], last. Outputs: grant valid and winner index. Purely combinational.

## Test plan
- Word write then read, port 0: write 0xBEEF @0x10, then read @0x10 → `ack0` at E+2, `rdata` = 0xBEEF; `mem[0x10]` = 0xBE, `mem[0x11]` = 0xEF.
- Byte write RMW: after word 0x1234 @0x20, byte-write 0xAB @0x20 → ack at E+3; word read @0x20 = 0xAB34; byte read @0x21 = 0x0034.
- Simultaneous requests held continuously, both ports reading → acks alternate 0,1,0,1. First grant goes to port 0, and every transaction after the first starts in the previous one's DONE cycle.
- Port 1 requests alone repeatedly, port 0 joins → port 0 granted at the next arbitration slot, with no starvation of either port.
- `reset` pulsed during RMW_RD of a byte write to 0x30 (prior 0x5566) → no ack, `mem_we` low at once, word @0x30 still 0x5566, next request serviced normally.
- `mem_we` never high in IDLE or DONE: check with an assertion across all scenarios.
